// File: rtl/can_pkg.sv
// Shared widths and sequencer state encoding for the CAN transmit queue.
package can_pkg;

   localparam int CAN_BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } can_txq_state_t;

endpackage

// File: rtl/can_byte_fifo.sv
// Circular byte FIFO; count is held separately so full and empty are both
// possible with equal pointers.
module can_byte_fifo
   import can_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic [CAN_BYTE_W-1:0]   wdata,
   output logic [CAN_BYTE_W-1:0]   rdata,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [CAN_BYTE_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  push_ok, pop_ok;

   // A push while full is dropped even if a pop frees a slot this cycle.
   assign push_ok = push && (count_q != CW'(DEPTH));
   assign pop_ok  = pop && (count_q != '0);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;

endmodule

// File: rtl/can_tx_queue.sv
// Byte queue plus send sequencer feeding the CAN controller's transmit port.
// Each queued byte is handed over exactly once: send pulse, then busy high/low.
module can_tx_queue
   import can_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              wr_data,
   input  logic                    wr_en,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic [7:0]              tx_data,
   output logic                    tx_send,
   input  logic                    tx_busy,
   output logic                    timeout_err,
   output logic [1:0]              state_dbg
);

   localparam int TW = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

   can_txq_state_t          state_q, state_d;
   logic [CAN_BYTE_W-1:0]   tx_data_q, tx_data_d;
   logic [TW-1:0]           timer_q, timer_d;
   logic                    overflow_q, overflow_d;
   logic                    pop;
   logic [CAN_BYTE_W-1:0]   fifo_rdata;

   can_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (reset),
      .push  (wr_en),
      .pop   (pop),
      .wdata (wr_data),
      .rdata (fifo_rdata),
      .full  (full),
      .count (count)
   );

   assign overflow_d = wr_en && full;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         tx_data_q  <= '0;
         timer_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         timer_q    <= timer_d;
         overflow_q <= overflow_d;
      end
   end

   // Handshake: tx_send is a one-cycle offer of tx_data; the controller
   // acknowledges by raising tx_busy, and the handoff completes when it drops.
   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      timer_d   = timer_q;
      pop       = 1'b0;
      case (state_q)
         IDLE: begin
            if ((count != '0) && !tx_busy) begin
               pop       = 1'b1;
               tx_data_d = fifo_rdata;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            timer_d = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy)                 state_d = WAIT_DONE;
            else if (timer_q == TMO_LAST) state_d = IDLE;
            else                         timer_d = timer_q + TW'(1);
         end
         WAIT_DONE: begin
            if (!tx_busy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tx_send     = (state_q == ISSUE);
      timeout_err = (state_q == WAIT_BUSY) && !tx_busy && (timer_q == TMO_LAST);
   end

   assign tx_data   = tx_data_q;
   assign overflow  = overflow_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_can_tx_queue.sv
// Directed bench for can_tx_queue: queue/handoff model, per-cycle compare,
// and literal checks of the key timing points.
module tb_can_tx_queue;

  localparam int DEPTH        = 8;
  localparam int BUSY_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic [3:0] count;
  logic       overflow;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_busy;
  logic       timeout_err;
  logic [1:0] state_dbg;

  // busy source: either a forced level or a controller model
  logic auto_mode;
  logic busy_force;
  logic ctrl_busy;
  int   ctrl_hold;
  int   busy_left;
  logic sent_seen;

  assign tx_busy = auto_mode ? ctrl_busy : busy_force;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // model state
  logic [7:0] exp_q[$];
  logic [7:0] m_data;
  logic       m_inflight;
  int         m_age;
  logic       m_saw;
  logic       exp_send;
  logic       exp_ovf;
  logic       exp_to;

  // logs
  logic [7:0] send_log[$];
  int         send_cyc[$];
  int         to_cyc[$];
  int         ovf_cnt;

  can_tx_queue #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .full        (full),
    .count       (count),
    .overflow    (overflow),
    .tx_data     (tx_data),
    .tx_send     (tx_send),
    .tx_busy     (tx_busy),
    .timeout_err (timeout_err),
    .state_dbg   (state_dbg)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    send_log.delete();
    send_cyc.delete();
    to_cyc.delete();
    ovf_cnt = 0;
  endtask

  task automatic wait_sends(input int n, input int budget);
    int k = 0;
    while (send_log.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("send_count_within_budget", send_log.size(), n);
  endtask

  // controller model: busy high for ctrl_hold cycles starting one cycle after send
  always @(negedge clk) sent_seen = tx_send;
  always @(posedge clk) begin
    #1;
    if (auto_mode && sent_seen) busy_left = ctrl_hold;
    if (busy_left > 0) begin
      ctrl_busy = 1'b1;
      busy_left--;
    end else begin
      ctrl_busy = 1'b0;
    end
  end

  // scoreboard: compare then advance the queue/handoff model each cycle
  always @(negedge clk) begin
    int pre;
    logic nxt_send;
    logic nxt_ovf;
    if (reset) begin
      exp_q.delete();
      m_data = 8'h00; m_inflight = 1'b0; m_age = 0; m_saw = 1'b0;
      exp_send = 1'b0; exp_ovf = 1'b0;
      chk("rst_count", count, 0);
      chk("rst_full", full, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_tx_send", tx_send, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_timeout_err", timeout_err, 0);
    end else begin
      exp_to = m_inflight && (m_age == BUSY_TIMEOUT) && !m_saw && !tx_busy;
      chk("count", count, exp_q.size());
      chk("full", full, exp_q.size() == DEPTH);
      chk("overflow", overflow, exp_ovf);
      chk("tx_send", tx_send, exp_send);
      chk("tx_data", tx_data, m_data);
      chk("timeout_err", timeout_err, exp_to);
      if (tx_send) begin
        send_log.push_back(tx_data);
        send_cyc.push_back(cyc);
      end
      if (timeout_err) to_cyc.push_back(cyc);
      if (overflow) ovf_cnt++;

      pre = exp_q.size();
      nxt_send = 1'b0;
      nxt_ovf  = wr_en && (pre == DEPTH);
      if (!m_inflight) begin
        if (pre > 0 && !tx_busy) begin
          m_data = exp_q.pop_front();
          nxt_send = 1'b1;
          m_inflight = 1'b1; m_age = 0; m_saw = 1'b0;
        end
      end else begin
        if (m_age > 0) begin
          if (m_saw) begin
            if (!tx_busy) m_inflight = 1'b0;
          end else if (tx_busy) begin
            m_saw = 1'b1;
          end else if (m_age == BUSY_TIMEOUT) begin
            m_inflight = 1'b0;
          end
        end
        m_age++;
      end
      if (wr_en && pre < DEPTH) exp_q.push_back(wr_data);
      exp_send = nxt_send;
      exp_ovf  = nxt_ovf;
    end
  end

  initial begin
    int k;
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
    auto_mode = 1'b0; busy_force = 1'b0; ctrl_busy = 1'b0;
    ctrl_hold = 10; busy_left = 0; sent_seen = 1'b0;
    clear_logs();
    repeat (3) step();
    reset = 1'b0;
    step();

    // single byte, busy held 10 cycles after send
    clear_logs();
    auto_mode = 1'b1; ctrl_hold = 10;
    wr_en = 1'b1; wr_data = 8'hA5;            // cycle 0
    step(); wr_en = 1'b0;                     // cycle 1
    @(negedge clk);
    chk("t1_count_c1", count, 1);
    chk("t1_send_c1", tx_send, 0);
    step();                                   // cycle 2
    @(negedge clk);
    chk("t1_send_c2", tx_send, 1);
    chk("t1_data_c2", tx_data, 8'hA5);
    chk("t1_count_c2", count, 0);
    repeat (16) step();
    chk("t1_sends", send_log.size(), 1);
    chk("t1_timeouts", to_cyc.size(), 0);
    chk("t1_state_idle", state_dbg, 0);

    // fill and overflow with busy held high
    clear_logs();
    auto_mode = 1'b0; busy_force = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
    end
    wr_en = 1'b0;
    @(negedge clk);
    chk("t2_count8", count, 8);
    chk("t2_full", full, 1);
    chk("t2_overflow_pulse", overflow, 1);
    step();
    chk("t2_ovf_count", ovf_cnt, 1);
    ctrl_hold = 3; auto_mode = 1'b1;
    wait_sends(8, 200);
    repeat (10) step();
    chk("t2_total_sends", send_log.size(), 8);
    for (int i = 0; i < send_log.size(); i++) chk("t2_order", send_log[i], i + 1);
    chk("t2_count_empty", count, 0);

    // pointer wrap with random gaps
    clear_logs();
    ctrl_hold = 2;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b0;
      repeat ($urandom_range(0, 3)) step();
      k = 0;
      while (full && k < 100) begin step(); k++; end
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      step();
    end
    wr_en = 1'b0;
    wait_sends(20, 400);
    repeat (8) step();
    chk("t3_total_sends", send_log.size(), 20);
    for (int i = 0; i < send_log.size(); i++) chk("t3_order", send_log[i], 8'h10 + i);
    chk("t3_ovf_count", ovf_cnt, 0);

    // timeout with busy tied low
    clear_logs();
    auto_mode = 1'b0; busy_force = 1'b0;
    wr_en = 1'b1; wr_data = 8'h3C; step();
    wr_data = 8'h3D; step();
    wr_en = 1'b0;
    wait_sends(2, 50);
    repeat (8) step();
    chk("t4_timeouts", to_cyc.size(), 2);
    if (to_cyc.size() == 2 && send_cyc.size() == 2) begin
      chk("t4_to_delay0", to_cyc[0] - send_cyc[0], 4);
      chk("t4_to_delay1", to_cyc[1] - send_cyc[1], 4);
      chk("t4_resend_gap", send_cyc[1] - to_cyc[0], 2);
      chk("t4_data0", send_log[0], 8'h3C);
      chk("t4_data1", send_log[1], 8'h3D);
    end

    // simultaneous push/pop, then reset during WAIT_DONE
    clear_logs();
    busy_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h51 + i); step();
    end
    wr_en = 1'b0; step();
    @(negedge clk);
    chk("t5_count3", count, 3);
    step();
    busy_force = 1'b0; wr_en = 1'b1; wr_data = 8'h54;   // IDLE->ISSUE cycle
    step(); wr_en = 1'b0;
    @(negedge clk);
    chk("t5_count_pushpop", count, 3);
    chk("t5_send", tx_send, 1);
    chk("t5_data", tx_data, 8'h51);
    step(); busy_force = 1'b1;                           // WAIT_BUSY sees busy
    step();                                              // WAIT_DONE
    chk("t5_in_wait_done", state_dbg, 3);
    #1 reset = 1'b1;
    #1;
    chk("t5_async_count", count, 0);
    chk("t5_async_full", full, 0);
    chk("t5_async_tx_data", tx_data, 0);
    chk("t5_async_tx_send", tx_send, 0);
    chk("t5_async_state", state_dbg, 0);
    step(); reset = 1'b0; busy_force = 1'b0;
    step();
    clear_logs();
    wr_en = 1'b1; wr_data = 8'h77;
    step(); wr_en = 1'b0;
    step();
    @(negedge clk);
    chk("t5_post_reset_send", tx_send, 1);
    chk("t5_post_reset_data", tx_data, 8'h77);
    repeat (10) step();
    chk("t5_post_reset_sends", send_log.size(), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
